// File: rtl/uart_tx_fifo.sv
// Buffered 8N1 serial transmitter fed by single-cycle byte pushes from the write decode.
// Latency: a byte pushed into an idle, empty block is popped one cycle later, and the start bit begins then.
// Backpressure: none; a push while full without a same-cycle pop is dropped and sets sticky overflow.
module uart_tx_fifo #(
    parameter int DIV        = 16,
    parameter int FIFO_DEPTH = 16,
    parameter int AW         = 4
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          wvalid,
    input  logic [7:0]    wdata,
    output logic          uart_tx,
    output logic          busy,
    output logic          empty,
    output logic          full,
    output logic [AW:0]   level,
    output logic          overflow
);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    state_t        state;
    logic [7:0]    sr;
    logic [2:0]    bit_cnt;
    logic [15:0]   baud_cnt;
    logic          baud_end;
    logic          pop;
    logic          push;

    logic [7:0]    mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [7:0]    head_dat;

    assign baud_end = (baud_cnt == 16'(DIV - 1));
    // Pops only happen from IDLE or on the final cycle of a STOP bit.
    assign pop      = !empty && ((state == IDLE) || ((state == STOP) && baud_end));
    assign push     = wvalid && (!full || pop);
    assign head_dat = mem[rd_ptr];
    assign empty    = (level == '0);
    assign full     = (level == (AW+1)'(FIFO_DEPTH));
    assign busy     = (state != IDLE);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            level    <= '0;
            overflow <= 1'b0;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + 1'b1;
            if (pop)
                rd_ptr <= rd_ptr + 1'b1;
            level <= level + {{AW{1'b0}}, push} - {{AW{1'b0}}, pop};
            if (wvalid && !push)
                overflow <= 1'b1;
        end
    end

    // Storage is not reset; the pointers and level define what is valid.
    // When full with a concurrent pop, wr_ptr == rd_ptr and the head is read before it is overwritten.
    always_ff @(posedge clock) begin
        if (push)
            mem[wr_ptr] <= wdata;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            uart_tx  <= 1'b1;
            sr       <= '0;
            bit_cnt  <= '0;
            baud_cnt <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (pop) begin
                        sr       <= head_dat;
                        uart_tx  <= 1'b0;
                        baud_cnt <= '0;
                        state    <= START;
                    end
                end
                START: begin
                    if (baud_end) begin
                        uart_tx  <= sr[0];
                        bit_cnt  <= '0;
                        baud_cnt <= '0;
                        state    <= DATA;
                    end else begin
                        baud_cnt <= baud_cnt + 16'd1;
                    end
                end
                DATA: begin
                    if (baud_end) begin
                        baud_cnt <= '0;
                        if (bit_cnt == 3'd7) begin
                            uart_tx <= 1'b1;
                            state   <= STOP;
                        end else begin
                            sr      <= {1'b0, sr[7:1]};
                            uart_tx <= sr[1];
                            bit_cnt <= bit_cnt + 3'd1;
                        end
                    end else begin
                        baud_cnt <= baud_cnt + 16'd1;
                    end
                end
                STOP: begin
                    if (baud_end) begin
                        baud_cnt <= '0;
                        if (pop) begin
                            sr      <= head_dat;
                            uart_tx <= 1'b0;
                            state   <= START;
                        end else begin
                            state   <= IDLE;
                        end
                    end else begin
                        baud_cnt <= baud_cnt + 16'd1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Directed and random checks for uart_tx_fifo with a byte scoreboard fed by a push-acceptance model.
module tb_uart_tx_fifo;

    localparam int DIV   = 4;
    localparam int DEPTH = 4;
    localparam int AW    = 2;
    localparam int FRAME = 10 * DIV;

    logic          clock;
    logic          reset;
    logic          wvalid;
    logic [7:0]    wdata;
    logic          uart_tx;
    logic          busy;
    logic          empty;
    logic          full;
    logic [AW:0]   level;
    logic          overflow;

    int checks   = 0;
    int failures = 0;

    logic [7:0] exp_q[$];
    logic [7:0] wq[$];
    int  m_level = 0;
    int  m_left  = 0;
    int  m_acc   = 0;
    logic m_ovf  = 1'b0;

    logic       dec_active = 1'b0;
    int         dec_t      = 0;
    int         rx_cnt     = 0;
    logic [7:0] rx_byte;

    uart_tx_fifo #(.DIV(DIV), .FIFO_DEPTH(DEPTH), .AW(AW)) dut (
        .clock    (clock),
        .reset    (reset),
        .wvalid   (wvalid),
        .wdata    (wdata),
        .uart_tx  (uart_tx),
        .busy     (busy),
        .empty    (empty),
        .full     (full),
        .level    (level),
        .overflow (overflow)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    // Reference: FIFO occupancy plus a frame countdown; a frame occupies FRAME cycles after its pop.
    initial begin
        logic m_pop;
        logic m_push;
        forever begin
            @(posedge clock or posedge reset);
            if (reset) begin
                m_level = 0;
                m_left  = 0;
                m_ovf   = 1'b0;
                exp_q.delete();
            end else begin
                m_pop  = (m_level != 0) && (m_left <= 1);
                m_push = wvalid && ((m_level != DEPTH) || m_pop);
                if (wvalid && !m_push)
                    m_ovf = 1'b1;
                if (m_push) begin
                    exp_q.push_back(wdata);
                    m_acc++;
                end
                m_level = m_level + int'(m_push) - int'(m_pop);
                if (m_pop)
                    m_left = FRAME;
                else if (m_left > 0)
                    m_left--;
            end
        end
    end

    // Line decoder: sample mid-bit on the falling clock edge.
    initial begin
        int k;
        forever begin
            @(negedge clock);
            if (reset) begin
                dec_active = 1'b0;
            end else if (!dec_active) begin
                if (uart_tx === 1'b0) begin
                    dec_active = 1'b1;
                    dec_t      = 0;
                end
            end else begin
                dec_t++;
                if (dec_t == DIV / 2) begin
                    chk("rx_start_bit", uart_tx, 0);
                end else if (dec_t > DIV / 2 && ((dec_t - DIV / 2) % DIV) == 0) begin
                    k = (dec_t - DIV / 2) / DIV;
                    if (k <= 8) begin
                        rx_byte[k-1] = uart_tx;
                    end else begin
                        chk("rx_stop_bit", uart_tx, 1);
                        chk("rx_expected_avail", exp_q.size() > 0, 1);
                        if (exp_q.size() > 0)
                            chk("rx_byte", rx_byte, exp_q.pop_front());
                        rx_cnt++;
                        dec_active = 1'b0;
                    end
                end
            end
        end
    end

    // Compare the line cycle by cycle against the frames for the bytes in wq, starting at a start bit.
    task automatic check_wave(input int nbytes);
        int fb;
        logic [7:0] b;
        logic exp;
        for (int i = 0; i < nbytes * FRAME; i++) begin
            fb  = (i / DIV) % 10;
            b   = wq[i / FRAME];
            exp = (fb == 0) ? 1'b0 : (fb == 9) ? 1'b1 : b[fb-1];
            chk("wave_tx", uart_tx, exp);
            chk("wave_busy", busy, 1);
            step();
        end
        chk("wave_end_busy", busy, 0);
        chk("wave_end_tx", uart_tx, 1);
    endtask

    task automatic wait_drain(input string tag);
        int n = 0;
        while ((exp_q.size() != 0 || busy || dec_active) && n < 2000) begin
            step();
            n++;
        end
        chk({tag, "_drain_timeout"}, n < 2000, 1);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        step();
        reset = 1'b0;
        step();
    endtask

    initial begin
        int rx0;
        int acc0;
        int bad;
        reset  = 1'b1;
        wvalid = 1'b0;
        wdata  = '0;
        #2;
        chk("rst_uart_tx", uart_tx, 1);
        chk("rst_busy", busy, 0);
        chk("rst_empty", empty, 1);
        chk("rst_full", full, 0);
        chk("rst_level", level, 0);
        chk("rst_overflow", overflow, 0);
        step();
        reset = 1'b0;
        step();

        // 1: single byte
        wvalid = 1'b1; wdata = 8'h55;
        step();
        wvalid = 1'b0;
        chk("t1_level_after_push", level, 1);
        chk("t1_empty_after_push", empty, 0);
        chk("t1_tx_still_idle", uart_tx, 1);
        step();
        chk("t1_empty_after_pop", empty, 1);
        wq = '{8'h55};
        check_wave(1);
        wait_drain("t1");

        // 2: two bytes back to back, no idle gap
        wvalid = 1'b1; wdata = 8'h41;
        step();
        wdata = 8'h42;
        step();
        wvalid = 1'b0;
        wq = '{8'h41, 8'h42};
        check_wave(2);
        wait_drain("t2");

        // 3: six bytes in a row, the sixth overflows
        rx0 = rx_cnt;
        for (int i = 0; i < 6; i++) begin
            wvalid = 1'b1; wdata = 8'h10 + 8'(i);
            step();
        end
        wvalid = 1'b0;
        chk("t3_full", full, 1);
        chk("t3_level", level, 4);
        chk("t3_overflow", overflow, 1);
        wait_drain("t3");
        chk("t3_frames", rx_cnt - rx0, 5);

        // 4: push on the final STOP cycle while full is accepted
        do_reset();
        rx0 = rx_cnt;
        for (int i = 0; i < 5; i++) begin
            wvalid = 1'b1; wdata = 8'h60 + 8'(i);
            step();
        end
        wvalid = 1'b0;
        chk("t4_full_before", full, 1);
        chk("t4_level_before", level, 4);
        repeat (36) step();
        wvalid = 1'b1; wdata = 8'h99;
        step();
        wvalid = 1'b0;
        chk("t4_level", level, 4);
        chk("t4_full", full, 1);
        chk("t4_overflow", overflow, 0);
        chk("t4_busy_b2b", busy, 1);
        wait_drain("t4");
        chk("t4_frames", rx_cnt - rx0, 6);

        // 5: reset during DATA bit 3
        wvalid = 1'b1; wdata = 8'h3C;
        step();
        wvalid = 1'b0;
        step();
        repeat (17) step();
        #2 reset = 1'b1;
        #1;
        chk("t5_tx_async", uart_tx, 1);
        chk("t5_level", level, 0);
        chk("t5_busy", busy, 0);
        step();
        reset = 1'b0;
        bad = 0;
        for (int i = 0; i < 50; i++) begin
            if (uart_tx !== 1'b1 || busy !== 1'b0)
                bad++;
            step();
        end
        chk("t5_no_residual", bad, 0);
        wvalid = 1'b1; wdata = 8'hA5;
        step();
        wvalid = 1'b0;
        step();
        wq = '{8'hA5};
        check_wave(1);
        wait_drain("t5");

        // 6: random traffic
        do_reset();
        rx0  = rx_cnt;
        acc0 = m_acc;
        for (int i = 0; i < 1000; i++) begin
            wvalid = 1'b1; wdata = 8'($urandom);
            step();
            wvalid = 1'b0;
            repeat ($urandom_range(0, 60)) step();
        end
        wait_drain("t6");
        chk("t6_frames", rx_cnt - rx0, m_acc - acc0);
        chk("t6_overflow", overflow, m_ovf);
        chk("t6_empty", empty, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
